// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode: first-word-fall-through head,
// valid/ready handshake on both sides, registered head-relative peek and synchronous flush.
module instr_queue #(
    parameter int IW    = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    input  logic          out_ready,
    input  logic          peek_en,
    input  logic [AW-1:0] peek_idx,
    output logic [IW-1:0] peek_instr,
    output logic          peek_hit,
    output logic [AW:0]   count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [IW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;
    logic [IW-1:0] r_peekInstr;
    logic          r_peekHit;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count;
    logic [AW-1:0] w_peekAddr;

    // The extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_count    = r_wrPtr - r_rdPtr;
    assign w_push     = in_valid && !w_full && !flush;
    assign w_pop      = !w_empty && out_ready && !flush;
    assign w_peekAddr = r_rdPtr[AW-1:0] + peek_idx;

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_instr  = r_mem[r_rdPtr[AW-1:0]];
    assign count      = w_count;
    assign peek_instr = r_peekInstr;
    assign peek_hit   = r_peekHit;

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    // Peek samples pre-edge pointers, so a same-cycle push or pop does not disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peekInstr <= '0;
            r_peekHit   <= 1'b0;
        end else if (flush) begin
            r_peekHit   <= 1'b0;
        end else if (peek_en) begin
            r_peekInstr <= r_mem[w_peekAddr];
            r_peekHit   <= ({1'b0, peek_idx} < w_count);
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue: reset, fill/drain, streaming, peek, flush and async reset.
module tb_instr_queue;

    localparam int IW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic          out_ready;
    logic          peek_en;
    logic [AW-1:0] peek_idx;
    logic [IW-1:0] peek_instr;
    logic          peek_hit;
    logic [AW:0]   count;

    int tests;
    int fails;

    instr_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
        .peek_en(peek_en), .peek_idx(peek_idx), .peek_instr(peek_instr),
        .peek_hit(peek_hit), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        peek_en   = 1'b0;
        peek_idx  = '0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pushOne(input logic [IW-1:0] v);
        in_valid = 1'b1;
        in_instr = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        #3;
        tests++; if (count !== 5'd0) begin fails++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (peek_hit !== 1'b0) begin fails++; $display("[TB] FAIL reset_peek_hit got=%b exp=0", peek_hit); end
        tests++; if (peek_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_peek_instr got=%h exp=0", peek_instr); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_push_three();
        doReset();
        pushOne(32'h11);
        tests++; if (out_valid !== 1'b1 || out_instr !== 32'h11) begin fails++; $display("[TB] FAIL first_push_latency got=%b/%h exp=1/00000011", out_valid, out_instr); end
        pushOne(32'h22);
        pushOne(32'h33);
        tests++; if (count !== 5'd3) begin fails++; $display("[TB] FAIL push3_count got=%0d exp=3", count); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL push3_out_valid got=%b exp=1", out_valid); end
        tests++; if (out_instr !== 32'h11) begin fails++; $display("[TB] FAIL push3_head got=%h exp=00000011", out_instr); end
    endtask

    task automatic test_fill_drain();
        doReset();
        for (int i = 0; i < 16; i++) pushOne(32'h100 + i);
        tests++; if (count !== 5'd16) begin fails++; $display("[TB] FAIL full_count got=%0d exp=16", count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_in_ready got=%b exp=0", in_ready); end
        pushOne(32'h1FF);
        tests++; if (count !== 5'd16) begin fails++; $display("[TB] FAIL overflow_count got=%0d exp=16", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests++; if (out_valid !== 1'b1 || out_instr !== 32'h100 + i) begin fails++; $display("[TB] FAIL drain_%0d got=%b/%h exp=1/%h", i, out_valid, out_instr, 32'h100 + i); end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || count !== 5'd0) begin fails++; $display("[TB] FAIL drained_empty got=%b/%0d exp=0/0", out_valid, count); end
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int i = 0; i < 4; i++) pushOne(32'h200 + i);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_instr = 32'h204 + k;
            tests++; if (out_instr !== 32'h200 + k || count !== 5'd4) begin fails++; $display("[TB] FAIL stream_%0d got=%h/%0d exp=%h/4", k, out_instr, count, 32'h200 + k); end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++; if (count !== 5'd4 || out_instr !== 32'h228) begin fails++; $display("[TB] FAIL stream_end got=%0d/%h exp=4/00000228", count, out_instr); end
    endtask

    task automatic test_peek();
        doReset();
        pushOne(32'hA0);
        pushOne(32'hA1);
        pushOne(32'hA2);
        peek_en  = 1'b1;
        peek_idx = 4'd2;
        tick();
        tests++; if (peek_instr !== 32'hA2 || peek_hit !== 1'b1) begin fails++; $display("[TB] FAIL peek_idx2 got=%h/%b exp=000000a2/1", peek_instr, peek_hit); end
        peek_idx = 4'd5;
        tick();
        tests++; if (peek_hit !== 1'b0) begin fails++; $display("[TB] FAIL peek_idx5_hit got=%b exp=0", peek_hit); end
        peek_idx = 4'd3;
        tick();
        tests++; if (peek_hit !== 1'b0) begin fails++; $display("[TB] FAIL peek_idx3_boundary got=%b exp=0", peek_hit); end
        peek_en  = 1'b0;
        peek_idx = 4'd0;
        tick();
        tests++; if (peek_hit !== 1'b0) begin fails++; $display("[TB] FAIL peek_hold got=%b exp=0", peek_hit); end
        // Peek at head while popping it: result uses pre-edge pointer.
        peek_en   = 1'b1;
        peek_idx  = 4'd0;
        out_ready = 1'b1;
        tick();
        peek_en   = 1'b0;
        out_ready = 1'b0;
        tests++; if (peek_instr !== 32'hA0 || peek_hit !== 1'b1) begin fails++; $display("[TB] FAIL peek_with_pop got=%h/%b exp=000000a0/1", peek_instr, peek_hit); end
        tests++; if (out_instr !== 32'hA1 || count !== 5'd2) begin fails++; $display("[TB] FAIL pop_after_peek got=%h/%0d exp=000000a1/2", out_instr, count); end
    endtask

    task automatic test_flush();
        doReset();
        for (int i = 0; i < 5; i++) pushOne(32'h300 + i);
        peek_en  = 1'b1;
        peek_idx = 4'd0;
        tick();
        tests++; if (peek_hit !== 1'b1) begin fails++; $display("[TB] FAIL preflush_peek_hit got=%b exp=1", peek_hit); end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hDEAD;
        out_ready = 1'b1;
        tick();
        idleInputs();
        tests++; if (count !== 5'd0) begin fails++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_out_valid got=%b exp=0", out_valid); end
        tests++; if (peek_hit !== 1'b0) begin fails++; $display("[TB] FAIL flush_peek_hit got=%b exp=0", peek_hit); end
        pushOne(32'h55);
        tests++; if (count !== 5'd1 || out_instr !== 32'h55) begin fails++; $display("[TB] FAIL post_flush_push got=%0d/%h exp=1/00000055", count, out_instr); end
    endtask

    task automatic test_async_reset();
        doReset();
        for (int i = 0; i < 7; i++) pushOne(32'h400 + i);
        tests++; if (count !== 5'd7) begin fails++; $display("[TB] FAIL prereset_count got=%0d exp=7", count); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (count !== 5'd0 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_reset got=%0d/%b exp=0/0", count, out_valid); end
        #1;
        rst = 1'b0;
        tick();
        pushOne(32'h77);
        tests++; if (out_valid !== 1'b1 || out_instr !== 32'h77 || count !== 5'd1) begin fails++; $display("[TB] FAIL after_reset_push got=%b/%h/%0d exp=1/00000077/1", out_valid, out_instr, count); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        idleInputs();
        #2;
        test_reset();
        test_push_three();
        test_fill_drain();
        test_back_to_back();
        test_peek();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
